// File: rtl/bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_ctrl
// Purpose  : Bit-serial ALU sequencer. Runs a full-width AND/OR/XOR/ADD/SUB
//            one bit per clock, LSB first, through a 1-bit result slice.
//            Uses a start/busy/done handshake toward the control unit.
// Ports    : clk       - system clock, rising edge
//            rst_n     - synchronous active-low reset
//            i_start   - request, accepted only in IDLE
//            i_op      - 000 AND, 001 OR, 010 ADD, 101 XOR, 110 SUB
//            i_a, i_b  - operands, captured on accept
//            o_busy    - high in RUN and DONE
//            o_done    - one-cycle pulse, result/flags valid
//            o_result  - result, held until the next accept
//            o_cout    - ADD carry / SUB not-borrow, 0 for logic ops
//            o_zero    - result == 0
//            o_err     - last accepted op was illegal
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_alu_ctrl #(
   parameter int WIDTH = 24,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_zero,
   output logic             o_err
);

   localparam logic [2:0] c_OP_AND = 3'b000;
   localparam logic [2:0] c_OP_OR  = 3'b001;
   localparam logic [2:0] c_OP_ADD = 3'b010;
   localparam logic [2:0] c_OP_XOR = 3'b101;
   localparam logic [2:0] c_OP_SUB = 3'b110;

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res_sh;
   logic [2:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;
   logic             r_err;

   logic             w_legal;
   logic             w_arith;
   logic             w_ai;
   logic             w_bi;
   logic             w_bit;
   logic             w_carry_next;
   logic             w_last;
   logic [WIDTH-1:0] w_res_next;

   // Legality is judged on the incoming opcode; the captured r_op is
   // therefore always one of the five legal codes.
   always_comb begin
      w_legal = 1'b0;
      case (i_op)
         c_OP_AND, c_OP_OR, c_OP_ADD, c_OP_XOR, c_OP_SUB: w_legal = 1'b1;
         default:                                         w_legal = 1'b0;
      endcase
   end

   // 1-bit result slice. SUB is a + ~b + 1: B inverted, carry seeded to 1.
   assign w_arith      = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
   assign w_ai         = r_a[0];
   assign w_bi         = r_b[0] ^ (r_op == c_OP_SUB);
   assign w_carry_next = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);

   always_comb begin
      w_bit = 1'b0;
      case (r_op)
         c_OP_AND: w_bit = w_ai & w_bi;
         c_OP_OR:  w_bit = w_ai | w_bi;
         c_OP_XOR: w_bit = w_ai ^ w_bi;
         default:  w_bit = w_ai ^ w_bi ^ r_carry;
      endcase
   end

   // New bit enters at the MSB; after WIDTH shifts the first bit sits at LSB.
   assign w_res_next = {w_bit, r_res_sh[WIDTH-1:1]};
   assign w_last     = (r_cnt == c_LAST);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // ---------------------------------------------------------------------
   // FSM next state / outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = w_legal ? S_RUN : S_DONE;
         end
         S_RUN: begin
            o_busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            o_busy       = 1'b1;
            o_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res_sh <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_legal) begin
                     r_a     <= i_a;
                     r_b     <= i_b;
                     r_op    <= i_op;
                     r_cnt   <= '0;
                     r_carry <= (i_op == c_OP_SUB);
                     r_err   <= 1'b0;
                  end else begin
                     // Illegal op: flags are final immediately, operands untouched.
                     r_err    <= 1'b1;
                     r_result <= '0;
                     r_cout   <= 1'b0;
                     r_zero   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_res_sh <= w_res_next;
               r_cnt    <= r_cnt + 1'b1;
               if (w_arith) r_carry <= w_carry_next;
               // Publish on the final bit so the values are valid during DONE.
               if (w_last) begin
                  r_result <= w_res_next;
                  r_cout   <= w_arith & w_carry_next;
                  r_zero   <= (w_res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;
   assign o_cout   = r_cout;
   assign o_zero   = r_zero;
   assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_alu_ctrl
// Purpose  : Self-checking bench for bit_serial_alu_ctrl: directed cases
//            followed by random operations against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_alu_ctrl;

   localparam int W = 24;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          zero;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit_serial_alu_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (start),
      .i_op     (op),
      .i_a      (a),
      .i_b      (b),
      .o_busy   (busy),
      .o_done   (done),
      .o_result (result),
      .o_cout   (cout),
      .o_zero   (zero),
      .o_err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the operation definitions.
   task automatic model(input logic [2:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        output logic [W-1:0] r, output logic c, output logic z, output logic e);
      logic [W:0] s;
      r = '0; c = 1'b0; e = 1'b0;
      case (op_v)
         3'b000: r = a_v & b_v;
         3'b001: r = a_v | b_v;
         3'b101: r = a_v ^ b_v;
         3'b010: begin s = {1'b0, a_v} + {1'b0, b_v}; r = s[W-1:0]; c = s[W]; end
         3'b110: begin r = a_v - b_v; c = (a_v >= b_v); end
         default: e = 1'b1;
      endcase
      z = (r == '0);
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   // Wait for done; returns the cycle number (accept-edge cycle = 1).
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 60) begin step(); n++; end
   endtask

   task automatic check_outputs(input string tag, input logic [2:0] op_v,
                                input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      logic [W-1:0] er; logic ec, ez, ee;
      model(op_v, a_v, b_v, er, ec, ez, ee);
      check({tag, " done"},   32'(done),   32'd1);
      check({tag, " busy"},   32'(busy),   32'd1);
      check({tag, " result"}, 32'(result), 32'(er));
      check({tag, " cout"},   32'(cout),   32'(ec));
      check({tag, " zero"},   32'(zero),   32'(ez));
      check({tag, " err"},    32'(err),    32'(ee));
   endtask

   // One full transaction from IDLE; leaves the DUT in IDLE.
   task automatic run_op(input string tag, input logic [2:0] op_v,
                         input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      logic [W-1:0] er; logic ec, ez, ee;
      int n;
      model(op_v, a_v, b_v, er, ec, ez, ee);
      start = 1'b1; op = op_v; a = a_v; b = b_v;
      step();
      start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      wait_done(n);
      check({tag, " latency"}, 32'(n), ee ? 32'd1 : 32'(W + 1));
      check_outputs(tag, op_v, a_v, b_v);
      step();
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " idle"},       32'(busy), 32'd0);
   endtask

   initial begin
      int n, t1, t2;
      logic [2:0] rop;
      start = 1'b0; op = 3'b000; a = '0; b = '0;
      rst_n = 1'b0;
      repeat (3) step();
      check("rst busy",   32'(busy),   32'd0);
      check("rst done",   32'(done),   32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst cout",   32'(cout),   32'd0);
      check("rst zero",   32'(zero),   32'd0);
      check("rst err",    32'(err),    32'd0);
      rst_n = 1'b1;
      step();

      // Reset in the 10th RUN cycle discards the operation.
      start = 1'b1; op = 3'b010; a = 24'h000005; b = 24'h000003;
      step();
      start = 1'b0;
      repeat (9) step();
      check("midrun busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      check("midrst busy",   32'(busy),   32'd0);
      check("midrst result", 32'(result), 32'd0);
      check("midrst done",   32'(done),   32'd0);
      rst_n = 1'b1;
      t1 = 0;
      for (int i = 0; i < 30; i++) begin step(); if (done) t1++; end
      check("midrst no done", 32'(t1), 32'd0);
      run_op("add 5+3", 3'b010, 24'h000005, 24'h000003);

      run_op("add carry",   3'b010, 24'hFFFFFF, 24'h000001);
      run_op("sub noborrow", 3'b110, 24'h000010, 24'h000001);
      run_op("sub borrow",  3'b110, 24'h000001, 24'h000002);
      run_op("and",         3'b000, 24'hF0F0F0, 24'hFF00FF);
      run_op("or",          3'b001, 24'hF0F0F0, 24'hFF00FF);
      run_op("xor",         3'b101, 24'hF0F0F0, 24'hFF00FF);
      run_op("illegal",     3'b011, 24'h123456, 24'h654321);

      // start pulsed mid-RUN must be ignored.
      start = 1'b1; op = 3'b010; a = 24'h000001; b = 24'h000001;
      step();
      start = 1'b0;
      repeat (5) step();
      start = 1'b1; op = 3'b000; a = 24'h000000; b = 24'h000000;
      step();
      start = 1'b0;
      wait_done(n);
      check("ignore latency", 32'(n + 6), 32'(W + 1));
      check_outputs("ignore", 3'b010, 24'h000001, 24'h000001);
      step();
      check("ignore idle", 32'(busy), 32'd0);

      // Back-to-back with start held high.
      start = 1'b1; op = 3'b101; a = 24'hA5A5A5; b = 24'h0F0F0F;
      step();
      wait_done(n);
      t1 = cyc;
      check_outputs("b2b first", 3'b101, 24'hA5A5A5, 24'h0F0F0F);
      a = 24'h123456; b = 24'hFEDCBA;
      step();
      check("b2b idle gap", 32'(busy), 32'd0);
      step();
      check("b2b accepted", 32'(busy), 32'd1);
      wait_done(n);
      t2 = cyc;
      start = 1'b0;
      check("b2b spacing", 32'(t2 - t1), 32'(W + 2));
      check_outputs("b2b second", 3'b101, 24'h123456, 24'hFEDCBA);
      step();

      // Random operations, all opcodes including illegal ones.
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 7));
         run_op("random", rop, W'($urandom), W'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
